// File: rtl/inst_rom_pipe_pkg.sv
// Package: inst_rom_pipe_pkg
// Purpose : Shared defaults and types for the instruction ROM pipeline, used by
//           fetch, decode and the ROM itself.
// Contents: INST_ADDR_W / INST_DATA_W / INST_NOP defaults, the per-stage
//           control struct and a read-latency legality helper.
package inst_rom_pipe_pkg;

  localparam int          INST_ADDR_W = 6;
  localparam int          INST_DATA_W = 32;
  localparam logic [31:0] INST_NOP    = 32'h0000_0000;

  // Control bits carried alongside the data through each pipeline stage.
  typedef struct packed {
    logic valid;
    logic err;
  } stage_ctl_t;

  function automatic bit rd_lat_legal(input int rd_lat);
    return (rd_lat == 1) || (rd_lat == 2);
  endfunction

endpackage

// File: rtl/inst_rom_pipe_rom_array.sv
// Module : rom_array
// Purpose: DEPTH x DATA_W instruction storage with a registered (synchronous)
//          read; this output register is stage 0 of the fetch data path.
// Ports  : clk, rst      clock / asynchronous active-high reset
//          en            stage advances this cycle
//          load          advance carries an in-range request (implies en)
//          addr          word address, only used when load=1
//          rd_data       registered read data (NOP_CODE on reset or bubble)
// Contents come from INIT_IMAGE, a packed image with word k at bits
// [k*DATA_W +: DATA_W]; words not set by the caller default to NOP_CODE.
module rom_array #(
  parameter int                      ADDR_W     = 6,
  parameter int                      DATA_W     = 32,
  parameter int                      DEPTH      = 64,
  parameter logic [DATA_W-1:0]       NOP_CODE   = '0,
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMAGE = {DEPTH{NOP_CODE}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rom_mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Unpack the image into a constant word array so the read maps onto ROM.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    assign rom_mem[gi] = INIT_IMAGE[gi*DATA_W +: DATA_W];
  end

  // load is only raised for addresses below DEPTH, so the index stays in range.
  always_comb begin
    rd_data_d = rd_data_q;
    if (en) begin
      rd_data_d = load ? rom_mem[addr] : NOP_CODE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= NOP_CODE;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_rom_pipe.sv
// Module : inst_rom_pipe
// Purpose: Instruction ROM between fetch and decode with a 1- or 2-cycle
//          registered read, valid/ready handshakes, global stall, synchronous
//          flush and an out-of-range flag.
// Ports  : clk, rst               clock / asynchronous active-high reset
//          req_valid, req_ready   fetch request handshake
//          req_addr               word address of the instruction
//          flush                  drop every in-flight request
//          resp_valid, resp_ready response handshake
//          resp_code              instruction word
//          resp_err               request address was >= DEPTH
module inst_rom_pipe
  import inst_rom_pipe_pkg::*;
#(
  parameter int                      ADDR_W     = INST_ADDR_W,
  parameter int                      DATA_W     = INST_DATA_W,
  parameter int                      DEPTH      = 64,
  parameter int                      RD_LAT     = 1,
  parameter logic [DATA_W-1:0]       NOP_CODE   = DATA_W'(INST_NOP),
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMAGE = {DEPTH{NOP_CODE}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_code,
  output logic              resp_err
);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
    $error("inst_rom_pipe: RD_LAT must be 1 or 2, got %0d", RD_LAT);
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("inst_rom_pipe: DEPTH %0d exceeds 2**ADDR_W", DEPTH);
  end

  logic adv;
  logic accept;
  logic in_range;
  logic data_en;
  logic [DATA_W-1:0] rom_data;

  stage_ctl_t [RD_LAT-1:0] ctl_d;
  stage_ctl_t [RD_LAT-1:0] ctl_q;

  // Global stall: every stage moves together when the output slot frees up.
  assign adv       = !resp_valid || resp_ready;
  assign req_ready = adv;
  // A flush cycle never captures the request, even when req_ready is high.
  assign accept    = req_valid && adv && !flush;
  // Constant-true when DEPTH covers the whole address space.
  assign in_range  = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));
  // Data registers hold on flush; only the valid bits are cleared.
  assign data_en   = adv && !flush;

  always_comb begin
    ctl_d = ctl_q;
    if (flush) begin
      for (int i = 0; i < RD_LAT; i++) begin
        ctl_d[i].valid = 1'b0;
      end
    end else if (adv) begin
      ctl_d[0].valid = accept;
      ctl_d[0].err   = accept && !in_range;
      for (int i = 1; i < RD_LAT; i++) begin
        ctl_d[i] = ctl_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q <= '0;
    end else begin
      ctl_q <= ctl_d;
    end
  end

  rom_array #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .NOP_CODE   (NOP_CODE),
    .INIT_IMAGE (INIT_IMAGE)
  ) u_rom (
    .clk     (clk),
    .rst     (rst),
    .en      (data_en),
    .load    (accept && in_range),
    .addr    (req_addr),
    .rd_data (rom_data)
  );

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] code1_d;
    logic [DATA_W-1:0] code1_q;

    always_comb begin
      code1_d = code1_q;
      if (data_en) begin
        code1_d = rom_data;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        code1_q <= NOP_CODE;
      end else begin
        code1_q <= code1_d;
      end
    end

    assign resp_code = code1_q;
  end else begin : g_lat1
    assign resp_code = rom_data;
  end

  assign resp_valid = ctl_q[RD_LAT-1].valid;
  assign resp_err   = ctl_q[RD_LAT-1].err;

endmodule

// File: tb/tb_inst_rom_pipe.sv
// Bench for inst_rom_pipe: three instances share one stimulus stream
//   a: RD_LAT=1, DEPTH=64   b: RD_LAT=2, DEPTH=64   c: RD_LAT=1, DEPTH=48
// Image: word k = 32'h1000_0000 + k.
module tb_inst_rom_pipe;

  function automatic logic [64*32-1:0] mk_img();
    logic [64*32-1:0] v;
    v = '0;
    for (int k = 0; k < 64; k++) begin
      v[k*32 +: 32] = 32'h1000_0000 + 32'(k);
    end
    return v;
  endfunction

  localparam logic [64*32-1:0] IMG = mk_img();

  logic clk, rst, req_valid, flush, resp_ready;
  logic [5:0] req_addr;
  logic rdy_a, val_a, err_a, rdy_b, val_b, err_b, rdy_c, val_c, err_c;
  logic [31:0] code_a, code_b, code_c;

  int n_chk  = 0;
  int n_pass = 0;

  inst_rom_pipe #(.ADDR_W(6), .DATA_W(32), .DEPTH(64), .RD_LAT(1),
                  .NOP_CODE(32'h0), .INIT_IMAGE(IMG)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a),
    .req_addr(req_addr), .flush(flush), .resp_valid(val_a),
    .resp_ready(resp_ready), .resp_code(code_a), .resp_err(err_a));

  inst_rom_pipe #(.ADDR_W(6), .DATA_W(32), .DEPTH(64), .RD_LAT(2),
                  .NOP_CODE(32'h0), .INIT_IMAGE(IMG)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b),
    .req_addr(req_addr), .flush(flush), .resp_valid(val_b),
    .resp_ready(resp_ready), .resp_code(code_b), .resp_err(err_b));

  localparam logic [48*32-1:0] IMG48 = IMG[48*32-1:0];

  inst_rom_pipe #(.ADDR_W(6), .DATA_W(32), .DEPTH(48), .RD_LAT(1),
                  .NOP_CODE(32'h0), .INIT_IMAGE(IMG48)) dut_c (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_c),
    .req_addr(req_addr), .flush(flush), .resp_valid(val_c),
    .resp_ready(resp_ready), .resp_code(code_c), .resp_err(err_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one rising edge, then step clear of it before driving/sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_addr = 6'd3; flush = 1'b0; resp_ready = 1'b1;

    // Reset held for 3 edges with a request present.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_valid_a", 32'(val_a), 32'd0);
      chk("rst_code_a",  code_a,     32'h0);
      chk("rst_valid_b", 32'(val_b), 32'd0);
    end
    rst = 1'b0; req_valid = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(rdy_a), 32'd1);

    // Streaming on RD_LAT=1: 0,1,2,63 back to back.
    cyc(); req_valid = 1'b1; req_addr = 6'd0; #1;
    chk("s_rdy", 32'(rdy_a), 32'd1);
    cyc(); req_addr = 6'd1; #1;
    chk("s_val0", 32'(val_a), 32'd1);
    chk("s_code0", code_a, 32'h1000_0000);
    cyc(); req_addr = 6'd2; #1;
    chk("s_code1", code_a, 32'h1000_0001);
    cyc(); req_addr = 6'd63; #1;
    chk("s_code2", code_a, 32'h1000_0002);
    cyc(); req_valid = 1'b0; #1;
    chk("s_code63", code_a, 32'h1000_003F);
    chk("s_err63", 32'(err_a), 32'd0);
    chk("s_val63", 32'(val_a), 32'd1);
    cyc();
    chk("s_idle", 32'(val_a), 32'd0);
    repeat (3) cyc();

    // Stall on RD_LAT=2: 5,6,7 with resp_ready low for 3 cycles once 5 is out.
    req_valid = 1'b1; req_addr = 6'd5;
    cyc(); req_addr = 6'd6; #1;
    chk("st_lat", 32'(val_b), 32'd0);
    cyc(); req_addr = 6'd7; resp_ready = 1'b0; #1;
    chk("st_val5", 32'(val_b), 32'd1);
    chk("st_code5_1", code_b, 32'h1000_0005);
    chk("st_rdy_1", 32'(rdy_b), 32'd0);
    for (int i = 2; i <= 3; i++) begin
      cyc();
      chk("st_code5_hold", code_b, 32'h1000_0005);
      chk("st_val_hold", 32'(val_b), 32'd1);
      chk("st_rdy_hold", 32'(rdy_b), 32'd0);
    end
    resp_ready = 1'b1; #1;
    chk("st_rdy_back", 32'(rdy_b), 32'd1);
    cyc(); req_valid = 1'b0; #1;
    chk("st_code6", code_b, 32'h1000_0006);
    chk("st_val6", 32'(val_b), 32'd1);
    cyc();
    chk("st_code7", code_b, 32'h1000_0007);
    chk("st_val7", 32'(val_b), 32'd1);
    cyc();
    chk("st_empty", 32'(val_b), 32'd0);
    repeat (2) cyc();

    // Flush on RD_LAT=2: 8,9 accepted, flush while 10 is presented.
    req_valid = 1'b1; req_addr = 6'd8;
    cyc(); req_addr = 6'd9;
    cyc(); req_addr = 6'd10; flush = 1'b1; resp_ready = 1'b0;
    cyc(); flush = 1'b0; resp_ready = 1'b1; req_addr = 6'd20; #1;
    chk("fl_cleared", 32'(val_b), 32'd0);
    chk("fl_rdy", 32'(rdy_b), 32'd1);
    cyc(); req_valid = 1'b0; #1;
    chk("fl_no_stale", 32'(val_b), 32'd0);
    cyc();
    chk("fl_val20", 32'(val_b), 32'd1);
    chk("fl_code20", code_b, 32'h1000_0014);
    cyc();
    chk("fl_done", 32'(val_b), 32'd0);
    repeat (2) cyc();

    // Flush with req_ready=1 on RD_LAT=1: request is still dropped.
    req_valid = 1'b1; req_addr = 6'd10; flush = 1'b1; #1;
    chk("fl1_rdy", 32'(rdy_a), 32'd1);
    cyc(); req_valid = 1'b0; flush = 1'b0; #1;
    chk("fl1_dropped", 32'(val_a), 32'd0);
    repeat (2) cyc();

    // Range on DEPTH=48: 47 then 50.
    req_valid = 1'b1; req_addr = 6'd47;
    cyc(); req_addr = 6'd50; #1;
    chk("rg_code47", code_c, 32'h1000_002F);
    chk("rg_err47", 32'(err_c), 32'd0);
    cyc(); req_valid = 1'b0; #1;
    chk("rg_val50", 32'(val_c), 32'd1);
    chk("rg_code50", code_c, 32'h0);
    chk("rg_err50", 32'(err_c), 32'd1);
    cyc();
    chk("rg_idle", 32'(val_c), 32'd0);
    repeat (2) cyc();

    // Async reset with two responses in flight on RD_LAT=2.
    req_valid = 1'b1; req_addr = 6'd30;
    cyc(); req_addr = 6'd31;
    cyc(); req_valid = 1'b0; #1;
    chk("ar_val30", 32'(val_b), 32'd1);
    chk("ar_code30", code_b, 32'h1000_001E);
    #1 rst = 1'b1;
    #1;
    chk("ar_val_drop", 32'(val_b), 32'd0);
    chk("ar_code_nop", code_b, 32'h0);
    cyc(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ar_no_stale", 32'(val_b), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
